// File: rtl/lift_pkg.sv
// Shared types for the multi-floor lift controller: FSM states, travel direction,
// and the width helper used to size the floor bus and the shared timer.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } lift_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } lift_dir_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int fw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by travel and door timing; tc_o is high while the
// count sits at zero. Updates on the falling clock edge like the rest of the lift.
module lift_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lift_ctrl_multi.sv
// SCAN-order lift controller: latches floor requests, travels toward them one floor
// per TRAVEL_CYCLES, and opens the door for DOOR_CYCLES at each requested floor.
module lift_ctrl_multi
  import lift_pkg::*;
#(
  parameter int  N_FLOORS      = 4,
  parameter int  TRAVEL_CYCLES = 2,
  parameter int  DOOR_CYCLES   = 3,
  localparam int FW            = fw_of(N_FLOORS)
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic [N_FLOORS-1:0] REQ,
  output logic [FW-1:0]       FLOOR,
  output logic                UP,
  output logic                DOWN,
  output logic                DOOR,
  output logic [N_FLOORS-1:0] PENDING,
  output lift_state_e         STATE
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = fw_of(TMAX);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(N_FLOORS - 1);

  lift_state_e         state_q, state_d;
  lift_dir_e           dir_q, dir_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] req_set, pend_clr;
  logic [FW-1:0]       step_floor;
  logic                at_limit;
  logic                above, below, step_ahead;
  logic                tmr_load, tmr_tc;
  logic [TW-1:0]       tmr_val;

  lift_timer #(.W(TW)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RES),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign step_floor = (state_q == ST_MOVE_DOWN) ? floor_q - FW'(1) : floor_q + FW'(1);
  assign at_limit   = (state_q == ST_MOVE_DOWN) ? (floor_q == '0) : (floor_q == TOP_FLOOR);

  // Pending requests relative to the current floor and to the floor being reached.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    step_ahead = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q)) above = 1'b1;
        if (i < int'(floor_q)) below = 1'b1;
        if ((state_q == ST_MOVE_DOWN) ? (i < int'(step_floor)) : (i > int'(step_floor)))
          step_ahead = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    pend_clr = '0;
    req_set  = REQ;
    // A call at the open door only holds it open; it is never latched.
    if (state_q == ST_DOOR) req_set[floor_q] = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          tmr_load = 1'b1;
          if (pending_q[floor_q]) begin
            state_d           = ST_DOOR;
            tmr_val           = DOOR_LOAD;
            pend_clr[floor_q] = 1'b1;
          end else if ((dir_q == DIR_UP && above) || (dir_q == DIR_DOWN && !below)) begin
            state_d = ST_MOVE_UP;
            dir_d   = DIR_UP;
            tmr_val = TRAVEL_LOAD;
          end else begin
            state_d = ST_MOVE_DOWN;
            dir_d   = DIR_DOWN;
            tmr_val = TRAVEL_LOAD;
          end
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (tmr_tc) begin
          if (at_limit) begin
            state_d = ST_IDLE;
          end else begin
            floor_d = step_floor;
            if (pending_q[step_floor]) begin
              state_d              = ST_DOOR;
              tmr_load             = 1'b1;
              tmr_val              = DOOR_LOAD;
              pend_clr[step_floor] = 1'b1;
            end else if (step_ahead) begin
              tmr_load = 1'b1;
              tmr_val  = TRAVEL_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DOOR: begin
        if (REQ[floor_q]) begin
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (tmr_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (pending_q | req_set) & ~pend_clr;
  end

  always_ff @(negedge CLK or negedge RES) begin
    if (!RES) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
    end
  end

  assign FLOOR   = floor_q;
  assign UP      = (state_q == ST_MOVE_UP);
  assign DOWN    = (state_q == ST_MOVE_DOWN);
  assign DOOR    = (state_q == ST_DOOR);
  assign PENDING = pending_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_lift_ctrl_multi.sv
// Bench for lift_ctrl_multi: directed scenarios checked cycle by cycle through an
// expected-output queue, then a random request stress with service-latency tracking.
module tb_lift_ctrl_multi;
  import lift_pkg::*;

  localparam int N       = 4;
  localparam int TC      = 2;
  localparam int DC      = 3;
  localparam int FW      = 2;
  localparam int VW      = FW + 3 + N;
  localparam int LAT_MAX = 4 * (2 * TC + DC);
  localparam int K_I = 0, K_U = 1, K_D = 2, K_O = 3;

  logic          clk;
  logic          res;
  logic [N-1:0]  req;
  logic [FW-1:0] floor;
  logic          up, down, door;
  logic [N-1:0]  pending;
  lift_state_e   state;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [VW-1:0] exp_q[$];
  string         scen = "";
  int            step_idx = 0;
  logic [N-1:0]  outst;
  int            t_req[N];

  lift_ctrl_multi #(
    .N_FLOORS      (N),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .CLK     (clk),
    .RES     (res),
    .REQ     (req),
    .FLOOR   (floor),
    .UP      (up),
    .DOWN    (down),
    .DOOR    (door),
    .PENDING (pending),
    .STATE   (state)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int k, input int f, input logic [N-1:0] p);
    return {f[FW-1:0], k == K_U, k == K_D, k == K_O, p};
  endfunction

  // Drive one request vector, let one falling edge happen, compare on the rising edge.
  task automatic step(input logic [N-1:0] r, input int k, input int f, input logic [N-1:0] p);
    logic [VW-1:0] got;
    logic [VW-1:0] exp;
    req = r;
    exp_q.push_back(pack(k, f, p));
    @(negedge clk);
    @(posedge clk);
    got = {floor, up, down, door, pending};
    exp = exp_q.pop_front();
    check($sformatf("%s.%0d {floor,up,down,door,pend}", scen, step_idx), got, exp);
    step_idx++;
  endtask

  task automatic rep(input int n, input int k, input int f, input logic [N-1:0] p);
    for (int j = 0; j < n; j++) step('0, k, f, p);
  endtask

  task automatic begin_scen(input string name);
    scen     = name;
    step_idx = 0;
  endtask

  task automatic service_scan(input int c);
    for (int i = 0; i < N; i++) begin
      if (outst[i] && door && (int'(floor) == i)) begin
        check($sformatf("latency f%0d age%0d within %0d", i, c - t_req[i], LAT_MAX),
              ((c - t_req[i]) <= LAT_MAX) ? 32'd1 : 32'd0, 32'd1);
        outst[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] r;
    res = 1'b0;
    req = '0;
    #2;
    check("rst floor", floor, 0);
    check("rst up/down/door", {up, down, door}, 0);
    check("rst pending", pending, 0);
    @(posedge clk);
    res = 1'b1;

    // Request at the current floor: latch, then door for three cycles.
    begin_scen("same_floor");
    step(4'b0001, K_I, 0, 4'b0001);
    rep(3, K_O, 0, 4'b0000);
    step('0, K_I, 0, 4'b0000);

    // Full climb from floor 0 to floor 3.
    begin_scen("climb");
    step(4'b1000, K_I, 0, 4'b1000);
    rep(2, K_U, 0, 4'b1000);
    rep(2, K_U, 1, 4'b1000);
    rep(2, K_U, 2, 4'b1000);
    rep(3, K_O, 3, 4'b0000);
    step('0, K_I, 3, 4'b0000);

    // Reposition to floor 1 (direction reverses from up to down).
    begin_scen("to_f1");
    step(4'b0010, K_I, 3, 4'b0010);
    rep(2, K_D, 3, 4'b0010);
    rep(2, K_D, 2, 4'b0010);
    rep(3, K_O, 1, 4'b0000);
    step('0, K_I, 1, 4'b0000);

    // Moving up from 1 toward 3, floors 0 and 2 requested mid-move: SCAN order.
    begin_scen("scan");
    step(4'b1000, K_I, 1, 4'b1000);
    step('0, K_U, 1, 4'b1000);
    step(4'b0101, K_U, 1, 4'b1101);
    rep(3, K_O, 2, 4'b1001);
    step('0, K_I, 2, 4'b1001);
    rep(2, K_U, 2, 4'b1001);
    rep(3, K_O, 3, 4'b0001);
    step('0, K_I, 3, 4'b0001);
    rep(2, K_D, 3, 4'b0001);
    rep(2, K_D, 2, 4'b0001);
    rep(2, K_D, 1, 4'b0001);
    rep(3, K_O, 0, 4'b0000);
    step('0, K_I, 0, 4'b0000);

    // Door at floor 2 re-called on its second cycle stays open three more cycles.
    begin_scen("door_hold");
    step(4'b0100, K_I, 0, 4'b0100);
    rep(2, K_U, 0, 4'b0100);
    rep(2, K_U, 1, 4'b0100);
    rep(2, K_O, 2, 4'b0000);
    step(4'b0100, K_O, 2, 4'b0000);
    rep(2, K_O, 2, 4'b0000);
    step('0, K_I, 2, 4'b0000);

    // Asynchronous reset while moving up with requests pending.
    begin_scen("async_rst");
    step(4'b1001, K_I, 2, 4'b1001);
    step('0, K_U, 2, 4'b1001);
    #1 res = 1'b0;
    #1;
    check("async_rst floor", floor, 0);
    check("async_rst up/down/door", {up, down, door}, 0);
    check("async_rst pending", pending, 0);
    @(negedge clk);
    @(posedge clk);
    res = 1'b1;
    rep(2, K_I, 0, 4'b0000);

    // Random sparse requests; calls at a stationary lift's own floor are withheld.
    outst = '0;
    for (int c = 0; c < 2000; c++) begin
      check("exclusive up/down/door", ((int'(up) + int'(down) + int'(door)) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("floor in range", (int'(floor) <= N - 1) ? 32'd1 : 32'd0, 32'd1);
      service_scan(c);
      r = '0;
      if ($urandom_range(0, 7) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
      if (!up && !down) r[floor] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (r[i] && !outst[i]) begin
          outst[i] = 1'b1;
          t_req[i] = c;
        end
      end
      req = r;
      @(negedge clk);
      @(posedge clk);
    end
    req = '0;
    for (int c = 2000; c < 2080; c++) begin
      service_scan(c);
      @(negedge clk);
      @(posedge clk);
    end
    check("drain outstanding", outst, 0);
    check("drain pending", pending, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
